i2s_rx_deserializer: RTL and testbench
======================================

// Module: i2s_rx_deserializer
// PURPOSE
//  Recovers stereo PCM from an I2S ADC link, entirely in the system clk domain.
//  Sits directly downstream of the two-flop synchronisers on bclk/lrclk/sdata:
//  it oversamples those synced levels, finds bclk rising edges, deserialises
//  each slot and presents {left,right} frames on a valid/ready interface.
// PARAMETERS
//  SAMPLE_WIDTH  24  bits captured per channel, MSB first; 1..SLOT_WIDTH
//  SLOT_WIDTH    32  bclk periods per channel slot; framing reference
//  CNT_W          6  bit-counter width; must satisfy 2**CNT_W > SLOT_WIDTH
// PORTS
//  clk            in   1          system clock; at least 4x bclk
//  rst_n          in   1          reset: synchronous, active-low
//  enable         in   1          0 = hold in SYNC, no frames produced
//  bclk_sync      in   1          bclk, already two-flop synchronised
//  lrclk_sync     in   1          lrclk, synchronised (0 = left slot)
//  sdata_sync     in   1          serial data, synchronised
//  out_left       out  SAMPLE_W   left sample, two's complement
//  out_right      out  SAMPLE_W   right sample
//  out_valid      out  1          frame available
//  out_ready      in   1          consumer accepts when valid&&ready
//  overrun        out  1          sticky: a frame was dropped
//  overrun_clr    in   1          1-cycle pulse clears overrun
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): all outputs 0; state=SYNC; counters 0.
//  bclk_q register; rise = bclk_sync & ~bclk_q. All sampling happens only on rise.
//  lr_q holds lrclk seen at the previous rise; chg = rise & (lrclk_sync != lr_q).
//  States:
//    SYNC: wait for the first chg (enable=1) -> RUN with cnt=0. No word is committed.
//    RUN:  enable=0 -> SYNC, discarding partial data; out_valid is unaffected.
//  Bit timing: I2S 1-bit delay. The rise after chg carries slot bit 0 (MSB).
//  On each non-chg rise:
//    - shift sdata in when cnt < SAMPLE_WIDTH;
//    - cnt++, saturating at all ones.
//  At a chg rise, in this order:
//    1. The data bit belongs to the ending slot (bit SLOT_WIDTH-1); shift it if cnt < SAMPLE_WIDTH.
//    2. Framing check: ok iff cnt == SLOT_WIDTH-1.
//    3. If ok, commit the word to the left or right holding reg per lr_q.
//    4. cnt = 0.
//  Framing error: the word is discarded and left_ok is cleared, so the pair is dropped.
//  Frame emit: when a right word commits and left_ok=1, the frame is emitted.
//    - out_valid rises on the clk after the chg rise (1 clk latency).
//    - left_ok is then cleared.
//  Handshake:
//    - out_left/out_right are stable while out_valid=1 and !out_ready.
//    - valid&&ready with no new frame -> out_valid=0 next clk.
//    - New frame in the same clk as valid&&ready: load new data, out_valid stays 1.
//    - New frame while valid&&!ready: new frame dropped, old data kept, overrun=1.
//  overrun_clr and a new overrun event in the same clk: set wins.
//  Sign: captured word is left-aligned MSB-first, no sign extension needed.
// CONFIGURATION
//  `I2S_RX_STATS_EN defined:
//    - adds outputs frame_count[31:0] (+1 per emitted frame, wraps);
//    - adds outputs frame_err_count[15:0] (+1 per framing error, saturates at FFFF);
//    - both reset to 0.
//  Not defined: these ports and their counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package speech_pkg:
//    - i2s_rx_state_t enum {SYNC, RUN};
//    - I2S_DEFAULT_SAMPLE_WIDTH=24, I2S_DEFAULT_SLOT_WIDTH=32.
//  Sub-module i2s_slot_shifter:
//    - holds the cnt/shift register;
//    - reports word and frame_ok at chg.
//  The top level holds the FSM, holding regs, output handshake and stats.
// TESTING
//  1. Send 32-bit slots, left=0xABCDEF, right=0x123456, ready=1.
//     -> out_left=ABCDEF, out_right=123456; out_valid high 1 clk per frame.
//  2. First partial right slot after reset.
//     -> no frame is emitted until a full left+right pair is seen.
//  3. ready=0 across 2 frames.
//     -> first frame held stable, second dropped, overrun=1.
//     -> overrun_clr pulse -> overrun=0.
//  4. Left slot shortened to 20 bclks.
//     -> that pair is not emitted; the next good pair is emitted.
//     -> with STATS_EN, frame_err_count=1.
//  5. rst_n=0 mid-slot then released.
//     -> outputs are 0; resync on the next lrclk edge; the first full pair is correct.
//  6. SAMPLE_WIDTH=SLOT_WIDTH=16, left=0x8001, right=0x7FFE.
//     -> the LSB taken on the chg edge is captured correctly.

Source files
------------

// File: rtl/speech_pkg.sv
// Shared types and defaults for the I2S receive path.
package speech_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } i2s_rx_state_t;

    localparam int unsigned I2S_DEFAULT_SAMPLE_WIDTH = 24;
    localparam int unsigned I2S_DEFAULT_SLOT_WIDTH   = 32;

endpackage

// File: rtl/i2s_slot_shifter.sv
// Per-slot bit counter and MSB-first shift register for the I2S receiver.
// `word` and `frame_ok` are only meaningful on an lrclk-change rise; `word`
// already includes the data bit carried on that rise (I2S 1-bit delay).
module i2s_slot_shifter
    import speech_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_DEFAULT_SLOT_WIDTH,
    parameter int CNT_W        = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    active,
    input  logic                    rise,
    input  logic                    chg,
    input  logic                    sdata,
    output logic [SAMPLE_WIDTH-1:0] word,
    output logic                    frame_ok
);

    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_WIDTH - 1);

    logic [CNT_W-1:0]        cnt;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [SAMPLE_WIDTH:0]   shreg_ext;
    logic                    shift_en;

    // Next shift value and framing verdict; the chg-rise bit is folded into word.
    always_comb begin
        shreg_ext = {shreg, sdata};
        shift_en  = active && rise && (cnt < CNT_SAMPLE);
        word      = shift_en ? shreg_ext[SAMPLE_WIDTH-1:0] : shreg;
        frame_ok  = (cnt == CNT_LAST);
    end

    // Shift captured bits and count bclk rises within the current slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (rise) begin
            if (shift_en) begin
                shreg <= shreg_ext[SAMPLE_WIDTH-1:0];
            end
            if (chg) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserialiser: edge detection, SYNC/RUN framing FSM, left holding
// register and valid/ready frame output with sticky overrun.
// Optional feature macro: I2S_RX_STATS_EN adds frame_count / frame_err_count.
module i2s_rx_deserializer
    import speech_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_DEFAULT_SLOT_WIDTH,
    parameter int CNT_W        = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    bclk_sync,
    input  logic                    lrclk_sync,
    input  logic                    sdata_sync,
    output logic [SAMPLE_WIDTH-1:0] out_left,
    output logic [SAMPLE_WIDTH-1:0] out_right,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    overrun_clr
`ifdef I2S_RX_STATS_EN
    ,
    output logic [31:0]             frame_count,
    output logic [15:0]             frame_err_count
`endif
);

    i2s_rx_state_t           state;
    logic                    bclk_q;
    logic                    lr_q;
    logic                    rise;
    logic                    chg;
    logic                    active;
    logic [SAMPLE_WIDTH-1:0] word;
    logic                    frame_ok;
    logic [SAMPLE_WIDTH-1:0] left_hold;
    logic                    left_ok;
    logic                    run_chg;
    logic                    left_commit;
    logic                    right_commit;
    logic                    frame_err;
    logic                    new_frame;
    logic                    load_frame;
    logic                    overrun_set;

    i2s_slot_shifter #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SLOT_WIDTH   (SLOT_WIDTH),
        .CNT_W        (CNT_W)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (active),
        .rise     (rise),
        .chg      (chg),
        .sdata    (sdata_sync),
        .word     (word),
        .frame_ok (frame_ok)
    );

    // Edge detection and slot-boundary decode.
    always_comb begin
        rise         = bclk_sync && !bclk_q;
        chg          = rise && (lrclk_sync != lr_q);
        active       = (state == RUN) && enable;
        run_chg      = active && chg;
        left_commit  = run_chg && frame_ok && !lr_q;
        right_commit = run_chg && frame_ok && lr_q;
        frame_err    = run_chg && !frame_ok;
        new_frame    = right_commit && left_ok;
        load_frame   = new_frame && (!out_valid || out_ready);
        overrun_set  = new_frame && out_valid && !out_ready;
    end

    // Previous bclk level and the lrclk level seen at the last bclk rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_q <= 1'b0;
            lr_q   <= 1'b0;
        end else begin
            bclk_q <= bclk_sync;
            if (rise) begin
                lr_q <= lrclk_sync;
            end
        end
    end

    // Framing FSM: lock on the first lrclk edge, drop back on disable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            case (state)
                SYNC:    if (enable && chg) state <= RUN;
                RUN:     if (!enable)       state <= SYNC;
                default:                    state <= SYNC;
            endcase
        end
    end

    // Left holding register; a framing error or disable breaks the pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_hold <= '0;
            left_ok   <= 1'b0;
        end else if (!active || frame_err) begin
            left_ok <= 1'b0;
        end else if (left_commit) begin
            left_hold <= word;
            left_ok   <= 1'b1;
        end else if (new_frame) begin
            left_ok <= 1'b0;
        end
    end

    // Output handshake: a new frame replaces an accepted one, else it is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_frame) begin
                out_left  <= left_hold;
                out_right <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_STATS_EN
    // Emitted-frame counter (wraps) and framing-error counter (saturates).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count     <= '0;
            frame_err_count <= '0;
        end else begin
            if (load_frame) begin
                frame_count <= frame_count + 1'b1;
            end
            if (frame_err && (frame_err_count != '1)) begin
                frame_err_count <= frame_err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench: a 24/32 instance and a 16/16 instance share one I2S link.
module tb_i2s_rx_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, bclk, lrclk, sdata, out_ready, overrun_clr;

    logic [23:0] a_left, a_right;
    logic        a_valid, a_overrun;
    logic [15:0] b_left, b_right;
    logic        b_valid, b_overrun;
`ifdef I2S_RX_STATS_EN
    logic [31:0] a_fc, b_fc;
    logic [15:0] a_ec, b_ec;
    logic [15:0] ec_before;
`endif

    i2s_rx_deserializer #(
        .SAMPLE_WIDTH (24),
        .SLOT_WIDTH   (32),
        .CNT_W        (6)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bclk_sync   (bclk),
        .lrclk_sync  (lrclk),
        .sdata_sync  (sdata),
        .out_left    (a_left),
        .out_right   (a_right),
        .out_valid   (a_valid),
        .out_ready   (out_ready),
        .overrun     (a_overrun),
        .overrun_clr (overrun_clr)
`ifdef I2S_RX_STATS_EN
        ,
        .frame_count     (a_fc),
        .frame_err_count (a_ec)
`endif
    );

    i2s_rx_deserializer #(
        .SAMPLE_WIDTH (16),
        .SLOT_WIDTH   (16),
        .CNT_W        (6)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bclk_sync   (bclk),
        .lrclk_sync  (lrclk),
        .sdata_sync  (sdata),
        .out_left    (b_left),
        .out_right   (b_right),
        .out_valid   (b_valid),
        .out_ready   (out_ready),
        .overrun     (b_overrun),
        .overrun_clr (overrun_clr)
`ifdef I2S_RX_STATS_EN
        ,
        .frame_count     (b_fc),
        .frame_err_count (b_ec)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [47:0] q_a[$];
    logic [31:0] q_b[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor for the 24-bit instance.
    logic        a_hold = 1'b0;
    logic [47:0] a_held;
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_hold && a_valid) check("a_hold_stable", {a_left, a_right}, a_held);
            if (a_valid && out_ready) begin
                if (q_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_frame actual=%h required=none", {a_left, a_right});
                end else begin
                    check("a_frame", {a_left, a_right}, q_a.pop_front());
                end
            end
            a_hold = a_valid && !out_ready;
            a_held = {a_left, a_right};
        end else begin
            a_hold = 1'b0;
        end
    end

    // Monitor for the 16-bit instance.
    logic        b_hold = 1'b0;
    logic [31:0] b_held;
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_hold && b_valid) check("b_hold_stable", {16'h0, b_left, b_right}, {16'h0, b_held});
            if (b_valid && out_ready) begin
                if (q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_frame actual=%h required=none", {b_left, b_right});
                end else begin
                    check("b_frame", {16'h0, b_left, b_right}, {16'h0, q_b.pop_front()});
                end
            end
            b_hold = b_valid && !out_ready;
            b_held = {b_left, b_right};
        end else begin
            b_hold = 1'b0;
        end
    end

    // Data bit j of a slot carrying an n-bit MSB-first word, zero padded.
    function automatic logic slot_bit(input logic [31:0] w, input int j, input int n);
        logic [31:0] tmp;
        tmp = w;
        return (j < n) ? tmp[n-1-j] : 1'b0;
    endfunction

    logic carry = 1'b0;

    task automatic send_bit(input logic lr, input logic d);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (4) @(posedge clk);
        #1;
        bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One slot: the first bit period still carries the previous slot's last bit.
    task automatic send_slot(input logic lr, input logic [31:0] w, input int len, input int n);
        for (int k = 0; k < len; k++) begin
            logic d;
            d = (k == 0) ? carry : slot_bit(w, k - 1, n);
            send_bit(lr, d);
        end
        carry = slot_bit(w, len - 1, n);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_a"}, {a_valid, a_overrun, a_left, a_right}, '0);
        check({name, "_b"}, {b_valid, b_overrun, b_left, b_right}, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        bclk        = 1'b0;
        lrclk       = 1'b0;
        sdata       = 1'b0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst_n  = 1'b1;
        enable = 1'b1;

        // Partial right slot first, then two good pairs with ready=1.
        send_slot(1'b1, 32'h5A5A5A, 10, 24);
        send_slot(1'b0, 32'hABCDEF, 32, 24);
        check("no_early_frame", {47'h0, a_valid}, 48'h0);
        q_a.push_back({24'hABCDEF, 24'h123456});
        send_slot(1'b1, 32'h123456, 32, 24);
        send_slot(1'b0, 32'h800001, 32, 24);
        q_a.push_back({24'h800001, 24'h7FFFFF});
        send_slot(1'b1, 32'h7FFFFF, 32, 24);
        send_slot(1'b0, 32'h111111, 32, 24);

        // Back-pressure across two frames.
        out_ready = 1'b0;
        q_a.push_back({24'h111111, 24'h222222});
        send_slot(1'b1, 32'h222222, 32, 24);
        send_slot(1'b0, 32'h333333, 32, 24);
        send_slot(1'b1, 32'h444444, 32, 24);
        send_slot(1'b0, 32'h555555, 32, 24);
        check("overrun_set", {47'h0, a_overrun}, 48'h1);
        check("held_frame", {a_left, a_right}, {24'h111111, 24'h222222});
        check("valid_while_stalled", {47'h0, a_valid}, 48'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drops_after_accept", {47'h0, a_valid}, 48'h0);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        check("overrun_cleared", {47'h0, a_overrun}, 48'h0);
        q_a.push_back({24'h555555, 24'h666666});
        send_slot(1'b1, 32'h666666, 32, 24);

        // Short left slot: that pair is dropped, the next one is emitted.
`ifdef I2S_RX_STATS_EN
        ec_before = a_ec;
`endif
        send_slot(1'b0, 32'h777777, 20, 24);
        send_slot(1'b1, 32'h888888, 32, 24);
        send_slot(1'b0, 32'h99AA55, 32, 24);
`ifdef I2S_RX_STATS_EN
        check("frame_err_count_delta", {32'h0, a_ec - ec_before}, 48'h1);
`endif
        q_a.push_back({24'h99AA55, 24'h0F0F0F});
        send_slot(1'b1, 32'h0F0F0F, 32, 24);

        // Reset in the middle of a left slot, then resynchronise.
        send_slot(1'b0, 32'hC3C3C3, 12, 24);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("mid_slot_reset");
        rst_n = 1'b1;
        send_slot(1'b0, 32'h000000, 20, 24);
        send_slot(1'b1, 32'hDEAD01, 32, 24);
        send_slot(1'b0, 32'hFEDCBA, 32, 24);
        q_a.push_back({24'hFEDCBA, 24'h13579B});
        send_slot(1'b1, 32'h13579B, 32, 24);
        send_slot(1'b0, 32'h000000, 32, 24);

        // 16-bit slots: exercises the LSB carried on the lrclk-change rise.
        send_slot(1'b1, 32'h0F0F, 16, 16);
        send_slot(1'b0, 32'h8001, 16, 16);
        q_b.push_back({16'h8001, 16'h7FFE});
        send_slot(1'b1, 32'h7FFE, 16, 16);
        send_slot(1'b0, 32'h1234, 16, 16);
        q_b.push_back({16'h1234, 16'hFEDC});
        send_slot(1'b1, 32'hFEDC, 16, 16);
        send_slot(1'b0, 32'h0000, 16, 16);
        repeat (20) @(posedge clk);
        #1;

        check("a_queue_drained", 48'(q_a.size()), 48'h0);
        check("b_queue_drained", 48'(q_b.size()), 48'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
